// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, data port and memory port of the shared-memory arbiter.
// Purely wiring, no latency.
// Ready and valid handshakes live here; the arbiter drives readys and responses.
interface mem_port_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   // fetch port
   logic                    if_req_valid_i;
   logic [ADDR_WIDTH-1:0]   if_req_addr_i;
   logic                    if_req_ready_o;
   logic                    if_flush_i;
   logic                    if_rsp_valid_o;
   logic [DATA_WIDTH-1:0]   if_rsp_rdata_o;
   // data port
   logic                    dm_req_valid_i;
   logic                    dm_req_we_i;
   logic [ADDR_WIDTH-1:0]   dm_req_addr_i;
   logic [DATA_WIDTH-1:0]   dm_req_wdata_i;
   logic [DATA_WIDTH/8-1:0] dm_req_be_i;
   logic                    dm_req_ready_o;
   logic                    dm_rsp_valid_o;
   logic [DATA_WIDTH-1:0]   dm_rsp_rdata_o;
   // memory port
   logic                    mem_req_o;
   logic                    mem_we_o;
   logic [ADDR_WIDTH-1:0]   mem_addr_o;
   logic [DATA_WIDTH-1:0]   mem_wdata_o;
   logic [DATA_WIDTH/8-1:0] mem_be_o;
   logic [DATA_WIDTH-1:0]   mem_rdata_i;
   // status
   logic                    busy_o;

   // arbiter side
   modport slave (
      input  if_req_valid_i, if_req_addr_i, if_flush_i,
      output if_req_ready_o, if_rsp_valid_o, if_rsp_rdata_o,
      input  dm_req_valid_i, dm_req_we_i, dm_req_addr_i, dm_req_wdata_i, dm_req_be_i,
      output dm_req_ready_o, dm_rsp_valid_o, dm_rsp_rdata_o,
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
      input  mem_rdata_i,
      output busy_o
   );

   // requesters and memory side
   modport master (
      output if_req_valid_i, if_req_addr_i, if_flush_i,
      input  if_req_ready_o, if_rsp_valid_o, if_rsp_rdata_o,
      output dm_req_valid_i, dm_req_we_i, dm_req_addr_i, dm_req_wdata_i, dm_req_be_i,
      input  dm_req_ready_o, dm_rsp_valid_o, dm_rsp_rdata_o,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
      output mem_rdata_i,
      input  busy_o
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between fetch and data ports.
// Grant is combinational; response appears MEM_LATENCY cycles after grant, one idle-return cycle follows.
// Readys drop for the whole access; data port has priority, a starvation counter forces a fetch win.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 3
) (
   input logic               clk,
   input logic               rst_n,
   mem_port_arbiter_if.slave bus
);
   localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state;
   logic            owner_dm;
   logic            owner_we;
   logic [LW-1:0]   lat_cnt;
   logic [SW-1:0]   starve_cnt;
   logic            drop_if;

   logic            starved;
   logic            grant_dm;
   logic            grant_if;
   logic            rsp_cycle;

   // Arbitration: fetch beats data only once it has lost STARVE_LIMIT times in a row.
   always_comb begin
      starved   = bus.if_req_valid_i && (starve_cnt == SW'(STARVE_LIMIT));
      grant_dm  = rst_n && (state == IDLE) && bus.dm_req_valid_i && !starved;
      grant_if  = rst_n && (state == IDLE) && bus.if_req_valid_i && !grant_dm;
      rsp_cycle = rst_n && (state == BUSY) && (lat_cnt == '0);
   end

   // Output steering: winner's fields go straight to memory, response goes to the owner.
   always_comb begin
      bus.if_req_ready_o = 1'b0;
      bus.dm_req_ready_o = 1'b0;
      bus.mem_req_o      = 1'b0;
      bus.mem_we_o       = 1'b0;
      bus.mem_addr_o     = '0;
      bus.mem_wdata_o    = '0;
      bus.mem_be_o       = '0;
      bus.if_rsp_valid_o = 1'b0;
      bus.if_rsp_rdata_o = '0;
      bus.dm_rsp_valid_o = 1'b0;
      bus.dm_rsp_rdata_o = '0;
      bus.busy_o         = rst_n && (state == BUSY);
      if (grant_dm) begin
         bus.dm_req_ready_o = 1'b1;
         bus.mem_req_o      = 1'b1;
         bus.mem_we_o       = bus.dm_req_we_i;
         bus.mem_addr_o     = bus.dm_req_addr_i;
         bus.mem_wdata_o    = bus.dm_req_wdata_i;
         bus.mem_be_o       = bus.dm_req_be_i;
      end else if (grant_if) begin
         bus.if_req_ready_o = 1'b1;
         bus.mem_req_o      = 1'b1;
         bus.mem_addr_o     = bus.if_req_addr_i;
      end
      if (rsp_cycle) begin
         if (owner_dm) begin
            bus.dm_rsp_valid_o = 1'b1;
            bus.dm_rsp_rdata_o = owner_we ? '0 : bus.mem_rdata_i;
         end else if (!(drop_if || bus.if_flush_i)) begin
            // a flush arriving in the response cycle itself still kills the response
            bus.if_rsp_valid_o = 1'b1;
            bus.if_rsp_rdata_o = bus.mem_rdata_i;
         end
      end
   end

   // Access sequencer: IDLE grants, BUSY counts down the memory latency then returns to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner_dm   <= 1'b0;
         owner_we   <= 1'b0;
         lat_cnt    <= '0;
         starve_cnt <= '0;
         drop_if    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_dm || grant_if) begin
                  state    <= BUSY;
                  lat_cnt  <= LW'(MEM_LATENCY - 1);
                  owner_dm <= grant_dm;
                  owner_we <= grant_dm && bus.dm_req_we_i;
                  drop_if  <= grant_if && bus.if_flush_i;
               end else begin
                  drop_if  <= 1'b0;
               end
               if (grant_if) begin
                  starve_cnt <= '0;
               end else if (grant_dm && bus.if_req_valid_i &&
                            (starve_cnt != SW'(STARVE_LIMIT))) begin
                  starve_cnt <= starve_cnt + 1'b1;
               end
            end
            BUSY: begin
               if (!owner_dm && bus.if_flush_i) begin
                  drop_if <= 1'b1;
               end
               if (lat_cnt == '0) begin
                  state   <= IDLE;
                  drop_if <= 1'b0;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: two arbiters (latency 2 and latency 1) share one random stimulus stream.
// A timeline model (grant cycle + latency) predicts every output each cycle.
// Directed scenarios at the start pin the model with literal expectations.
module tb_mem_port_arbiter;
   localparam int LIMIT = 3;

   typedef struct packed {
      logic        if_rdy;
      logic        if_rv;
      logic [31:0] if_rd;
      logic        dm_rdy;
      logic        dm_rv;
      logic [31:0] dm_rd;
      logic        mreq;
      logic        mwe;
      logic [31:0] maddr;
      logic [31:0] mwd;
      logic [3:0]  mbe;
      logic        busy;
   } out_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_v = 1'b0, flush = 1'b0, dm_v = 1'b0, dm_we = 1'b0;
   logic [31:0] if_a = '0, dm_a = '0, dm_wd = '0, mrd = '0;
   logic [3:0]  dm_be = '0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
   mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

   mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(2), .STARVE_LIMIT(LIMIT))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
   mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1), .STARVE_LIMIT(LIMIT))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

   assign bus0.if_req_valid_i = if_v;  assign bus1.if_req_valid_i = if_v;
   assign bus0.if_req_addr_i  = if_a;  assign bus1.if_req_addr_i  = if_a;
   assign bus0.if_flush_i     = flush; assign bus1.if_flush_i     = flush;
   assign bus0.dm_req_valid_i = dm_v;  assign bus1.dm_req_valid_i = dm_v;
   assign bus0.dm_req_we_i    = dm_we; assign bus1.dm_req_we_i    = dm_we;
   assign bus0.dm_req_addr_i  = dm_a;  assign bus1.dm_req_addr_i  = dm_a;
   assign bus0.dm_req_wdata_i = dm_wd; assign bus1.dm_req_wdata_i = dm_wd;
   assign bus0.dm_req_be_i    = dm_be; assign bus1.dm_req_be_i    = dm_be;
   assign bus0.mem_rdata_i    = mrd;   assign bus1.mem_rdata_i    = mrd;

   out_t act [2];
   assign act[0] = {bus0.if_req_ready_o, bus0.if_rsp_valid_o, bus0.if_rsp_rdata_o,
                    bus0.dm_req_ready_o, bus0.dm_rsp_valid_o, bus0.dm_rsp_rdata_o,
                    bus0.mem_req_o, bus0.mem_we_o, bus0.mem_addr_o, bus0.mem_wdata_o,
                    bus0.mem_be_o, bus0.busy_o};
   assign act[1] = {bus1.if_req_ready_o, bus1.if_rsp_valid_o, bus1.if_rsp_rdata_o,
                    bus1.dm_req_ready_o, bus1.dm_rsp_valid_o, bus1.dm_rsp_rdata_o,
                    bus1.mem_req_o, bus1.mem_we_o, bus1.mem_addr_o, bus1.mem_wdata_o,
                    bus1.mem_be_o, bus1.busy_o};

   task automatic chk(input string nm, input int k, input logic [255:0] a, input logic [255:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s inst=%0d t=%0t actual=%0h required=%0h", nm, k, $time, a, e);
      end
   endtask

   // ---------------- timeline model ----------------
   // An access granted in cycle g occupies the memory until g+L, responds in g+L,
   // and the port may grant again from g+L+1 on.
   int  n = 0;
   bit  fl [2] = '{0, 0};
   int  g  [2] = '{0, 0};
   bit  own_dm [2] = '{0, 0};
   bit  own_we [2] = '{0, 0};
   bit  drop [2] = '{0, 0};
   int  starve [2] = '{0, 0};

   always @(negedge clk) begin
      n++;
      for (int k = 0; k < 2; k++) begin
         automatic int   lat = (k == 0) ? 2 : 1;
         automatic bit   idle = !fl[k] || (n > g[k] + lat);
         automatic bit   dmw = 1'b0;
         automatic bit   ifw = 1'b0;
         automatic out_t e = '0;
         if (rst_n) begin
            if (idle) begin
               dmw = dm_v && !(if_v && starve[k] == LIMIT);
               ifw = if_v && !dmw;
               e.dm_rdy = dmw;
               e.if_rdy = ifw;
               e.mreq   = dmw || ifw;
               if (dmw) begin
                  e.mwe = dm_we; e.maddr = dm_a; e.mwd = dm_wd; e.mbe = dm_be;
               end else if (ifw) begin
                  e.maddr = if_a;
               end
            end else begin
               e.busy = 1'b1;
               if (n == g[k] + lat) begin
                  if (own_dm[k]) begin
                     e.dm_rv = 1'b1;
                     e.dm_rd = own_we[k] ? 32'h0 : mrd;
                  end else if (!(drop[k] || flush)) begin
                     e.if_rv = 1'b1;
                     e.if_rd = mrd;
                  end
               end
            end
         end
         chk("handshake", k, {act[k].if_rdy, act[k].dm_rdy, act[k].mreq, act[k].busy},
                             {e.if_rdy, e.dm_rdy, e.mreq, e.busy});
         chk("response", k, {act[k].if_rv, act[k].if_rd, act[k].dm_rv, act[k].dm_rd},
                            {e.if_rv, e.if_rd, e.dm_rv, e.dm_rd});
         chk("mem_fields", k, {act[k].mwe, act[k].maddr, act[k].mwd, act[k].mbe},
                              {e.mwe, e.maddr, e.mwd, e.mbe});
         // advance the model across the coming clock edge
         if (!rst_n) begin
            fl[k] = 0; drop[k] = 0; starve[k] = 0;
         end else if (idle) begin
            fl[k] = dmw || ifw;
            if (fl[k]) begin
               g[k] = n; own_dm[k] = dmw; own_we[k] = dmw && dm_we; drop[k] = ifw && flush;
            end
            if (ifw) starve[k] = 0;
            else if (dmw && if_v && starve[k] < LIMIT) starve[k]++;
         end else if (!own_dm[k] && flush) begin
            drop[k] = 1;
         end
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int    grants;
      int    budget;
      logic [4:0] seq;
      // reset state with requests pending: readys must stay low
      if_v = 1'b1; dm_v = 1'b1;
      smp();
      chk("reset_outputs", 0, act[0], '0);
      chk("reset_outputs", 1, act[1], '0);
      next(); next();
      rst_n = 1'b1; if_v = 1'b0; dm_v = 1'b0;
      smp();

      // lone fetch
      next(); if_v = 1'b1; if_a = 32'h100; mrd = 32'h1111_0100;
      smp();
      chk("t1_if_ready", 0, act[0].if_rdy, 1);
      chk("t1_mem_req", 0, act[0].mreq, 1);
      chk("t1_mem_addr", 0, act[0].maddr, 32'h100);
      chk("t1_mem_we", 0, act[0].mwe, 0);
      next(); if_v = 1'b0;
      smp();
      chk("t1_busy", 0, act[0].busy, 1);
      chk("t1_no_early_rsp", 0, act[0].if_rv, 0);
      next();
      smp();
      chk("t1_rsp_valid", 0, act[0].if_rv, 1);
      chk("t1_rsp_rdata", 0, act[0].if_rd, 32'h1111_0100);

      // both valid: data store wins, grantable again at T+3
      next(); if_v = 1'b1; if_a = 32'h104;
      dm_v = 1'b1; dm_we = 1'b1; dm_a = 32'h200; dm_wd = 32'hDEAD_BEEF; dm_be = 4'hF;
      smp();
      chk("t2_dm_ready", 0, act[0].dm_rdy, 1);
      chk("t2_if_loses", 0, act[0].if_rdy, 0);
      chk("t2_mem_we", 0, act[0].mwe, 1);
      chk("t2_mem_wdata", 0, act[0].mwd, 32'hDEAD_BEEF);
      chk("t2_mem_addr", 0, act[0].maddr, 32'h200);
      chk("t2_mem_be", 0, act[0].mbe, 4'hF);
      next(); dm_v = 1'b0; dm_we = 1'b0;
      smp();
      chk("t2_if_blocked", 0, act[0].if_rdy, 0);
      next();
      smp();
      chk("t2_dm_ack", 0, act[0].dm_rv, 1);
      chk("t2_ack_rdata", 0, act[0].dm_rd, 0);
      chk("t2_no_grant_rsp_cycle", 0, act[0].if_rdy, 0);
      next();
      smp();
      chk("t2_if_granted", 0, act[0].if_rdy, 1);
      chk("t2_if_addr", 0, act[0].maddr, 32'h104);

      // flush during the fetch access just granted
      next(); if_v = 1'b0; flush = 1'b1;
      smp();
      chk("t4_busy_t1", 0, act[0].busy, 1);
      next(); flush = 1'b0;
      smp();
      chk("t4_rsp_dropped", 0, act[0].if_rv, 0);
      chk("t4_busy_t2", 0, act[0].busy, 1);
      next();
      smp();
      chk("t4_idle_t3", 0, act[0].busy, 0);
      next(); next();

      // latency-1 port: load then store ack
      next(); dm_v = 1'b1; dm_we = 1'b0; dm_a = 32'h300; mrd = 32'h6666_0001;
      smp();
      chk("t6_load_ready", 1, act[1].dm_rdy, 1);
      next(); dm_v = 1'b0;
      smp();
      chk("t6_load_rsp", 1, act[1].dm_rv, 1);
      chk("t6_load_rdata", 1, act[1].dm_rd, 32'h6666_0001);
      next();
      next(); dm_v = 1'b1; dm_we = 1'b1; dm_wd = 32'h1234_5678;
      smp();
      chk("t6_store_ready", 1, act[1].dm_rdy, 1);
      next(); dm_v = 1'b0; dm_we = 1'b0;
      smp();
      chk("t6_store_ack", 1, act[1].dm_rv, 1);
      chk("t6_store_rdata", 1, act[1].dm_rd, 0);
      next(); next(); next();

      // reset in the middle of an access
      next(); if_v = 1'b1; if_a = 32'h400;
      smp();
      chk("t5_granted", 0, act[0].if_rdy, 1);
      next(); dm_v = 1'b1; rst_n = 1'b0;
      smp();
      chk("t5_outputs_zero", 0, act[0], '0);
      chk("t5_outputs_zero", 1, act[1], '0);
      next(); rst_n = 1'b1; if_v = 1'b0; dm_v = 1'b0;
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("t5_no_stale_rsp", 0, {act[0].if_rv, act[0].dm_rv}, 0);
         chk("t5_idle", 0, act[0].busy, 0);
         next();
      end

      // starvation: both ports request continuously
      if_v = 1'b1; dm_v = 1'b1; dm_we = 1'b0; dm_a = 32'h500;
      grants = 0; budget = 0; seq = '0;
      while (grants < 5 && budget < 40) begin
         smp();
         if (act[0].mreq) begin
            seq[grants] = act[0].if_rdy;
            grants++;
         end
         budget++;
         next();
      end
      chk("t3_grant_count", 0, grants, 5);
      chk("t3_grant_order", 0, seq, 5'b01000);
      if_v = 1'b0; dm_v = 1'b0;
      next(); next(); next();

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         next();
         rst_n = ($urandom_range(0, 299) != 0);
         if_v  = ($urandom_range(0, 2) != 0);
         dm_v  = ($urandom_range(0, 1) != 0);
         flush = ($urandom_range(0, 7) == 0);
         dm_we = $urandom_range(0, 1);
         if_a  = $urandom; dm_a = $urandom; dm_wd = $urandom;
         dm_be = 4'($urandom); mrd = $urandom;
      end
      next();
      smp();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
